// File: rtl/team_06_wb_sram_responder_pkg.sv
// Shared types for the Wishbone SRAM responder: FSM states, captured request
// and bus widths.
package team_06_wb_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_SELW = 4;

  typedef enum logic [1:0] {WB_IDLE, WB_WAIT, WB_ACK} wb_state_t;

  typedef struct packed {
    logic                 we;
    logic [WB_DW-1:0]     adr;
    logic [WB_DW-1:0]     dat;
    logic [WB_SELW-1:0]   sel;
  } wb_req_t;

  function automatic logic [WB_DW-1:0] lane_mask(input logic [WB_SELW-1:0] sel);
    logic [WB_DW-1:0] mask;
    mask = '0;
    for (int unsigned k = 0; k < WB_SELW; k++) begin
      mask[8*k +: 8] = {8{sel[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/team_06_wb_sram_responder_if.sv
// Wishbone classic B4 bus between a manager (master) and the SRAM responder (slave).
interface team_06_wb_sram_responder_if;
  import team_06_wb_pkg::*;

  logic                 CYC_I;
  logic                 STB_I;
  logic                 WE_I;
  logic [WB_DW-1:0]     ADR_I;
  logic [WB_DW-1:0]     DAT_I;
  logic [WB_SELW-1:0]   SEL_I;
  logic [WB_DW-1:0]     DAT_O;
  logic                 ACK_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I,
    output DAT_O, ACK_O
  );

endinterface

// File: rtl/team_06_wb_sram_array.sv
// DEPTH x 32 single-port SRAM with per-byte write enables and a registered read port.
module team_06_wb_sram_array
  import team_06_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 8192,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [WB_SELW-1:0]  be,
  input  logic                re,
  input  logic [AW-1:0]       addr,
  input  logic [WB_DW-1:0]    wdata,
  output logic [WB_DW-1:0]    rdata
);

  logic [WB_DW-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned k = 0; k < WB_SELW; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/team_06_wb_sram_responder.sv
// Wishbone classic responder: address-window decode, wait-state insertion and
// byte-lane handling in front of a word-addressed SRAM.
module team_06_wb_sram_responder
  import team_06_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
  parameter int unsigned DEPTH       = 8192,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] OOR_DATA    = 32'hBAD0_BAD0
) (
  input  logic                          clk,
  input  logic                          nRST,
  team_06_wb_sram_responder_if.slave    bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  wb_state_t            state, next_state;
  wb_req_t              req_q, eff;
  logic [3:0]           cnt_q, cnt_d;
  logic                 request, enter_ack, in_range;
  logic [WB_DW-1:0]     offset, rdata;
  logic [AW-1:0]        word_idx;
  logic                 rd_q, oor_q;
  logic [WB_SELW-1:0]   sel_q;

  assign request = bus.CYC_I & bus.STB_I;

  // In IDLE the live bus is the effective request so a zero-wait transfer can
  // commit/read on its capture edge; afterwards the held copy is used.
  always_comb begin
    if (state == WB_IDLE) begin
      eff.we  = bus.WE_I;
      eff.adr = bus.ADR_I;
      eff.dat = bus.DAT_I;
      eff.sel = bus.SEL_I;
    end else begin
      eff = req_q;
    end
  end

  assign offset   = eff.adr - BASE_ADDR;
  assign in_range = offset < 4 * DEPTH;
  assign word_idx = AW'(offset >> 2);

  always_comb begin
    next_state = state;
    cnt_d      = cnt_q;
    unique case (state)
      WB_IDLE: begin
        if (request) begin
          if (WAIT_STATES == 0) begin
            next_state = WB_ACK;
          end else begin
            next_state = WB_WAIT;
            cnt_d      = WS_LOAD;
          end
        end
      end
      WB_WAIT: begin
        if (!bus.CYC_I)        next_state = WB_IDLE;
        else if (cnt_q == '0)  next_state = WB_ACK;
        else                   cnt_d      = cnt_q - 4'd1;
      end
      WB_ACK:  next_state = WB_IDLE;
      default: next_state = WB_IDLE;
    endcase
  end

  assign enter_ack = (next_state == WB_ACK);

  team_06_wb_sram_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (nRST & enter_ack & eff.we & in_range),
    .be    (eff.sel),
    .re    (enter_ack & ~eff.we & in_range),
    .addr  (word_idx),
    .wdata (eff.dat),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state <= WB_IDLE;
      cnt_q <= '0;
      req_q <= '0;
      rd_q  <= 1'b0;
      oor_q <= 1'b0;
      sel_q <= '0;
    end else begin
      state <= next_state;
      cnt_q <= cnt_d;
      if (state == WB_IDLE && request) req_q <= eff;
      if (enter_ack) begin
        rd_q  <= ~eff.we;
        oor_q <= ~in_range;
        sel_q <= eff.sel;
      end
    end
  end

  assign bus.ACK_O = (state == WB_ACK);
  assign bus.DAT_O = (bus.ACK_O && rd_q) ?
                     ((oor_q ? OOR_DATA : rdata) & lane_mask(sel_q)) : '0;

endmodule

// File: tb/tb_team_06_wb_sram_responder.sv
// Directed + randomized bench for the Wishbone SRAM responder, two instances
// (WAIT_STATES=1 full depth, WAIT_STATES=3 small depth) checked against a word model.
module tb_team_06_wb_sram_responder;

  localparam logic [31:0] BASE = 32'h3300_0000;
  localparam logic [31:0] OOR  = 32'hBAD0_BAD0;
  localparam int unsigned D0 = 8192, WS0 = 1;
  localparam int unsigned D1 = 64,   WS1 = 3;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic [3:0]  sel = '0;
  int unsigned which = 0;

  int checks = 0, failures = 0;
  int stb_count = 0, ack_events = 0;

  logic [31:0] mem0 [int unsigned];
  logic [31:0] mem1 [int unsigned];

  team_06_wb_sram_responder_if bus0 ();
  team_06_wb_sram_responder_if bus1 ();

  assign bus0.CYC_I = cyc & (which == 0);
  assign bus0.STB_I = stb & (which == 0);
  assign bus0.WE_I  = we;
  assign bus0.ADR_I = adr;
  assign bus0.DAT_I = dat;
  assign bus0.SEL_I = sel;
  assign bus1.CYC_I = cyc & (which == 1);
  assign bus1.STB_I = stb & (which == 1);
  assign bus1.WE_I  = we;
  assign bus1.ADR_I = adr;
  assign bus1.DAT_I = dat;
  assign bus1.SEL_I = sel;

  logic        ack;
  logic [31:0] rdat;
  assign ack  = (which == 0) ? bus0.ACK_O : bus1.ACK_O;
  assign rdat = (which == 0) ? bus0.DAT_O : bus1.DAT_O;

  team_06_wb_sram_responder #(
    .BASE_ADDR(BASE), .DEPTH(D0), .WAIT_STATES(WS0), .OOR_DATA(OOR)
  ) dut0 (.clk(clk), .nRST(nRST), .bus(bus0));

  team_06_wb_sram_responder #(
    .BASE_ADDR(BASE), .DEPTH(D1), .WAIT_STATES(WS1), .OOR_DATA(OOR)
  ) dut1 (.clk(clk), .nRST(nRST), .bus(bus1));

  always @(negedge clk) ack_events += int'(bus0.ACK_O) + int'(bus1.ACK_O);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bytemask(input logic [3:0] s);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = s[k] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic int unsigned ws_of(input int unsigned w);
    return (w == 0) ? WS0 : WS1;
  endfunction

  // Reference: a word store updated lane-by-lane, OOR reads give the constant.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] exp);
    logic [31:0] off, m, old;
    int unsigned idx, depth;
    bit inr;
    depth = (which == 0) ? D0 : D1;
    off = a - BASE;
    inr = (off < 4 * depth);
    idx = off / 4;
    m   = bytemask(s);
    if (which == 0) old = mem0.exists(idx) ? mem0[idx] : '0;
    else            old = mem1.exists(idx) ? mem1[idx] : '0;
    if (w) begin
      exp = '0;
      if (inr) begin
        if (which == 0) mem0[idx] = (old & ~m) | (d & m);
        else            mem1[idx] = (old & ~m) | (d & m);
      end
    end else begin
      exp = inr ? (old & m) : (OOR & m);
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string tag, output logic [31:0] rd);
    logic [31:0] exp;
    int unsigned n;
    bit got;
    model(w, a, d, s, exp);
    we = w; adr = a; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    stb_count++;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ack === 1'b1) got = 1'b1;
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    rd = '0;
    if (got) begin
      check({tag, "_lat"}, n, ws_of(which) + 1);
      rd = rdat;
      if (!w) check({tag, "_dat"}, rdat, exp);
      @(posedge clk); #1;
      check({tag, "_once"}, 32'(ack), 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n, input string tag);
    cyc = 1'b0; stb = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check({tag, "_noack"}, 32'(ack), 32'd0);
      check({tag, "_dat0"}, rdat, 32'd0);
    end
  endtask

  logic [31:0] rd;
  int          acks_before;

  initial begin
    // 1: reset held with a request pending
    which = 0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_ack0", 32'(bus0.ACK_O), 32'd0);
      check("rst_dat0", bus0.DAT_O, 32'd0);
      check("rst_ack1", 32'(bus1.ACK_O), 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    nRST = 1'b1;
    idle_cycles(2, "post_rst");

    // 2: full-word write and readback
    xfer(1'b1, BASE + 32'h10, 32'hCAFE_F00D, 4'hF, "wr10", rd);
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, "rd10", rd);
    check("rd10_lit", rd, 32'hCAFE_F00D);

    // 3: byte lanes, including an empty select
    xfer(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF, "wr20", rd);
    xfer(1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, "wr20p", rd);
    xfer(1'b0, BASE + 32'h20, 32'h0, 4'hF, "rd20", rd);
    check("rd20_lit", rd, 32'h11BB_33DD);
    xfer(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'b0000, "wr20z", rd);
    xfer(1'b0, BASE + 32'h20, 32'h0, 4'b0110, "rd20m", rd);
    check("rd20m_lit", rd, 32'h00BB_3300);

    // 4: out of range, one past the window and one below it
    xfer(1'b1, BASE, 32'h0102_0304, 4'hF, "wr0", rd);
    xfer(1'b1, BASE + 4 * D0, 32'h5555_5555, 4'hF, "wr_oor", rd);
    xfer(1'b0, BASE, 32'h0, 4'hF, "rd0", rd);
    check("rd0_lit", rd, 32'h0102_0304);
    xfer(1'b0, BASE + 4 * D0, 32'h0, 4'hF, "rd_oor", rd);
    check("rd_oor_lit", rd, 32'hBAD0_BAD0);
    xfer(1'b0, BASE - 32'd4, 32'h0, 4'b0011, "rd_below", rd);
    check("rd_below_lit", rd, 32'h0000_BAD0);
    idle_cycles(2, "idle4");

    // 5: abort during WAIT on the 3-wait-state instance
    which = 1;
    xfer(1'b1, BASE, 32'h1234_5678, 4'hF, "w1_wr0", rd);
    we = 1'b1; adr = BASE; dat = 32'h0000_00FF; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    idle_cycles(6, "abort");
    xfer(1'b0, BASE, 32'h0, 4'hF, "w1_rd0", rd);
    check("abort_lit", rd, 32'h1234_5678);

    // reset landing on the edge that would commit a write
    xfer(1'b1, BASE + 32'h4, 32'h0000_0055, 4'hF, "w1_wr4", rd);
    we = 1'b1; adr = BASE + 32'h4; dat = 32'hDEAD_BEEF; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nRST = 1'b0;
    @(posedge clk); #1;
    check("midrst_ack", 32'(ack), 32'd0);
    cyc = 1'b0; stb = 1'b0; nRST = 1'b1;
    idle_cycles(2, "midrst");
    xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, "w1_rd4", rd);
    check("midrst_lit", rd, 32'h0000_0055);

    // 6: back-to-back burst of 16 writes then 16 reads on each instance
    for (int unsigned w = 0; w < 2; w++) begin
      which = w;
      acks_before = ack_events;
      for (int i = 0; i < 16; i++)
        xfer(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, "b2b_wr", rd);
      for (int i = 0; i < 16; i++)
        xfer(1'b0, BASE + 32'(4 * i), 32'h0, 4'hF, "b2b_rd", rd);
      idle_cycles(1, "b2b_end");
      check("b2b_acks", 32'(ack_events - acks_before), 32'd32);
    end

    // randomized mix over the prefilled words plus out-of-range addresses
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      int unsigned r, dep;
      which = $urandom_range(0, 1);
      dep = (which == 0) ? D0 : D1;
      r = $urandom_range(0, 15);
      case ($urandom_range(0, 7))
        0:       a = BASE + 32'(4 * dep) + 32'(4 * r);
        1:       a = BASE - 32'd4 - 32'(4 * r);
        default: a = BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
      endcase
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rnd", rd);
      if ($urandom_range(0, 3) == 0) idle_cycles(1, "rnd_gap");
    end

    idle_cycles(2, "final");
    check("ack_per_stb", 32'(ack_events), 32'(stb_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
